// File: rtl/simd_lane_regfile_pkg.sv
// Shared types and helpers for the lane-maskable SIMD vector register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package SimdRfPkg;

    // Default lane geometry for register-file instances.
    localparam int RF_VSIZE = 4;
    localparam int RF_TDBW  = 16;

    // Clear-engine states.
    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    // One lane's data word at the default width.
    typedef logic [RF_TDBW-1:0] lane_dat_t;

    // Address width for a word count that need not be a power of two.
    function automatic int RF_ABW(input int nword);
        return (nword > 1) ? $clog2(nword) : 1;
    endfunction

endpackage

// File: rtl/simd_lane_bank.sv
// One lane of vector storage: single masked write port, NRD combinational read muxes.
// Latency: write lands on the clock edge; reads are combinational (the top registers them).
// Backpressure: none; the caller guarantees i_waddr < NWORD whenever i_we is set.
// Ports: i_clk; i_we/i_waddr/i_wdata write port; i_raddr[NRD] read addresses -> o_rdata[NRD].
module simd_lane_bank #(
    parameter int TDBW  = 16,
    parameter int NWORD = 64,
    parameter int NRD   = 2,
    parameter int ABW   = 6
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [ABW-1:0]            i_waddr,
    input  logic [TDBW-1:0]           i_wdata,
    input  logic [NRD-1:0][ABW-1:0]   i_raddr,
    output logic [NRD-1:0][TDBW-1:0]  o_rdata
);

    // Not reset: contents are defined only after a write or a clear pass.
    logic [TDBW-1:0] mem [NWORD];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Out-of-range read addresses return don't-care here; the top zeroes them.
    always_comb begin
        o_rdata = '0;
        for (int p = 0; p < NRD; p++) begin
            o_rdata[p] = mem[i_raddr[p]];
        end
    end

endmodule

// File: rtl/simd_lane_regfile.sv
// Lane-maskable multi-read-port vector register file with bypass and self-timed clear.
// Latency: reads return one cycle after i_re; writes visible next cycle (same cycle with FWD=1).
// Backpressure: none on reads/writes; while o_busy (NWORD cycles) reads, writes and clears are ignored.
// Ports: i_clk/i_rst; i_we/i_waddr/i_wmask/i_wdata write; i_re/i_raddr -> o_rdata/o_rvalid per port;
//        i_clr starts a clear of every word, o_busy high while it runs.
module simd_lane_regfile
    import SimdRfPkg::*;
#(
    parameter int VSIZE = RF_VSIZE,
    parameter int TDBW  = RF_TDBW,
    parameter int NWORD = 64,
    parameter int NRD   = 2,
    parameter int FWD   = 1,
    parameter int ABW   = RF_ABW(NWORD)
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_we,
    input  logic [ABW-1:0]                      i_waddr,
    input  logic [VSIZE-1:0]                    i_wmask,
    input  logic [VSIZE-1:0][TDBW-1:0]          i_wdata,
    input  logic [NRD-1:0]                      i_re,
    input  logic [NRD-1:0][ABW-1:0]             i_raddr,
    output logic [NRD-1:0][VSIZE-1:0][TDBW-1:0] o_rdata,
    output logic [NRD-1:0]                      o_rvalid,
    input  logic                                i_clr,
    output logic                                o_busy
);

    rf_state_t      state_q, state_d;
    logic [ABW-1:0] cnt_q, cnt_d;
    logic           clr_active;
    logic           wr_ok;

    logic [VSIZE-1:0]                    bank_we;
    logic [ABW-1:0]                      bank_waddr;
    logic [VSIZE-1:0][TDBW-1:0]          bank_wdata;
    logic [VSIZE-1:0][NRD-1:0][TDBW-1:0] bank_rd;
    logic [NRD-1:0][VSIZE-1:0][TDBW-1:0] rd_d;

    // One extra bit so NWORD itself is representable when it is a power of two.
    function automatic logic in_range(input logic [ABW-1:0] a);
        return ({1'b0, a} < (ABW+1)'(NWORD));
    endfunction

    assign clr_active = (state_q == RF_CLEAR);
    assign o_busy     = clr_active;

    // A clear request in the same cycle wins over a write.
    assign wr_ok = !clr_active && i_we && !i_clr && in_range(i_waddr);

    // ---------------- clear engine ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_IDLE: begin
                if (i_clr) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            RF_CLEAR: begin
                if (cnt_q == ABW'(NWORD - 1)) begin
                    state_d = RF_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RF_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- storage banks ----------------
    assign bank_waddr = clr_active ? cnt_q : i_waddr;

    always_comb begin
        bank_we    = '0;
        bank_wdata = '0;
        for (int l = 0; l < VSIZE; l++) begin
            bank_we[l]    = clr_active || (wr_ok && i_wmask[l]);
            bank_wdata[l] = clr_active ? '0 : i_wdata[l];
        end
    end

    for (genvar l = 0; l < VSIZE; l++) begin : g_lane
        simd_lane_bank #(
            .TDBW  (TDBW),
            .NWORD (NWORD),
            .NRD   (NRD),
            .ABW   (ABW)
        ) u_bank (
            .i_clk   (i_clk),
            .i_we    (bank_we[l]),
            .i_waddr (bank_waddr),
            .i_wdata (bank_wdata[l]),
            .i_raddr (i_raddr),
            .o_rdata (bank_rd[l])
        );
    end

    // ---------------- read path ----------------
    // Banks return pre-write data; with FWD the written lanes are substituted
    // so a same-cycle reader sees the merged (new where masked, old elsewhere) word.
    always_comb begin
        rd_d = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int l = 0; l < VSIZE; l++) begin
                if (in_range(i_raddr[p])) begin
                    if ((FWD != 0) && wr_ok && i_wmask[l] && (i_waddr == i_raddr[p])) begin
                        rd_d[p][l] = i_wdata[l];
                    end else begin
                        rd_d[p][l] = bank_rd[l][p];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rdata  <= '0;
            o_rvalid <= '0;
        end else begin
            for (int p = 0; p < NRD; p++) begin
                o_rvalid[p] <= !clr_active && i_re[p];
                if (!clr_active && i_re[p]) begin
                    o_rdata[p] <= rd_d[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_simd_lane_regfile.sv
module tb_simd_lane_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              we;
    logic [5:0]        waddr;
    logic [3:0]        wmask;
    logic [3:0][15:0]  wdata;
    logic [1:0]        re;
    logic [1:0][5:0]   raddr;
    logic              clr;

    logic [1:0][3:0][15:0] rdata_a, rdata_b;
    logic [1:0]            rvalid_a, rvalid_b;
    logic                  busy_a, busy_b;

    // Instance a: 64 words with bypass. Instance b: 48 words, no bypass.
    simd_lane_regfile #(.VSIZE(4), .TDBW(16), .NWORD(64), .NRD(2), .FWD(1)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_we(we), .i_waddr(waddr), .i_wmask(wmask),
        .i_wdata(wdata), .i_re(re), .i_raddr(raddr), .o_rdata(rdata_a),
        .o_rvalid(rvalid_a), .i_clr(clr), .o_busy(busy_a));

    simd_lane_regfile #(.VSIZE(4), .TDBW(16), .NWORD(48), .NRD(2), .FWD(0)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_we(we), .i_waddr(waddr), .i_wmask(wmask),
        .i_wdata(wdata), .i_re(re), .i_raddr(raddr), .o_rdata(rdata_b),
        .o_rvalid(rvalid_b), .i_clr(clr), .o_busy(busy_b));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain arrays of lane values, X where undefined.
    int          nw  [2] = '{64, 48};
    bit          fwd [2] = '{1'b1, 1'b0};
    logic [15:0] mdl [2][64][4];
    int          clr_left [2];
    logic [63:0] last_dat [2][2];
    bit          mon_en = 1'b0;

    typedef struct {
        int          d;
        int          p;
        int          cyc;
        logic [63:0] dat;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mdl_forget();
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w++)
                for (int l = 0; l < 4; l++)
                    mdl[d][w][l] = 'x;
    endtask

    // Apply one cycle of stimulus; model predicts using the pre-edge state.
    task automatic drive(input logic i_we_v, input logic [5:0] wa, input logic [3:0] wm,
                         input logic [63:0] wd, input logic [1:0] rv,
                         input logic [5:0] ra0, input logic [5:0] ra1, input logic cl);
        we = i_we_v; waddr = wa; wmask = wm; wdata = wd;
        re = rv; raddr[0] = ra0; raddr[1] = ra1; clr = cl;
        for (int d = 0; d < 2; d++) begin
            if (clr_left[d] == 0) begin
                bit wr_takes;
                wr_takes = i_we_v && !cl && (int'(wa) < nw[d]);
                for (int p = 0; p < 2; p++) begin
                    if (rv[p]) begin
                        exp_t e;
                        int   a;
                        a = (p == 0) ? int'(ra0) : int'(ra1);
                        e.d = d; e.p = p; e.cyc = cyc; e.dat = '0;
                        if (a < nw[d]) begin
                            for (int l = 0; l < 4; l++) begin
                                if (fwd[d] && wr_takes && int'(wa) == a && wm[l])
                                    e.dat[l*16 +: 16] = wd[l*16 +: 16];
                                else
                                    e.dat[l*16 +: 16] = mdl[d][a][l];
                            end
                        end
                        q.push_back(e);
                    end
                end
                if (cl) begin
                    clr_left[d] = nw[d];
                end else if (wr_takes) begin
                    for (int l = 0; l < 4; l++)
                        if (wm[l]) mdl[d][wa][l] = wd[l*16 +: 16];
                end
            end else begin
                for (int l = 0; l < 4; l++) mdl[d][nw[d] - clr_left[d]][l] = 16'h0;
                clr_left[d]--;
            end
        end
        @(posedge clk);
        #1;
        chk("busy_a", {63'd0, busy_a}, {63'd0, clr_left[0] > 0});
        chk("busy_b", {63'd0, busy_b}, {63'd0, clr_left[1] > 0});
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 4'd0, 64'd0, 2'b00, 6'd0, 6'd0, 1'b0);
    endtask

    task automatic rd2(input logic [5:0] a0, input logic [5:0] a1);
        drive(1'b0, 6'd0, 4'd0, 64'd0, 2'b11, a0, a1, 1'b0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [3:0] m, input logic [63:0] d);
        drive(1'b1, a, m, d, 2'b00, 6'd0, 6'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        mon_en = 1'b1;
        clr_left[0] = 0; clr_left[1] = 0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) last_dat[d][p] = '0;
        chk("rst_busy", {62'd0, busy_b, busy_a}, 64'd0);
        chk("rst_rvalid", {60'd0, rvalid_b, rvalid_a}, 64'd0);
        chk("rst_rdata_a", rdata_a[0] | rdata_a[1], 64'd0);
        chk("rst_rdata_b", rdata_b[0] | rdata_b[1], 64'd0);
        mdl_forget();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Run a clear to completion, returning the busy-cycle counts seen on each instance.
    task automatic run_clear(output int na, output int nb);
        drive(1'b0, 6'd0, 4'd0, 64'd0, 2'b00, 6'd0, 6'd0, 1'b1);
        na = 0; nb = 0;
        for (int i = 0; i < 200 && (busy_a || busy_b); i++) begin
            na += int'(busy_a);
            nb += int'(busy_b);
            idle();
        end
    endtask

    // Monitor: pops the oldest matching expectation whenever a port presents valid data.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    logic        rv;
                    logic [63:0] rdv;
                    int          idx;
                    rv  = (d == 0) ? rvalid_a[p] : rvalid_b[p];
                    rdv = (d == 0) ? rdata_a[p] : rdata_b[p];
                    if (rv === 1'b1) begin
                        idx = -1;
                        for (int i = 0; i < q.size(); i++) begin
                            if (q[i].d == d && q[i].p == p) begin
                                idx = i;
                                break;
                            end
                        end
                        if (idx < 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_rvalid d%0d p%0d: got 1 expected 0 (cycle %0d)", d, p, cyc);
                        end else begin
                            chk($sformatf("latency_d%0d_p%0d", d, p), 64'(cyc), 64'(q[idx].cyc + 1));
                            chk($sformatf("rdata_d%0d_p%0d", d, p), rdv, q[idx].dat);
                            last_dat[d][p] = q[idx].dat;
                            q.delete(idx);
                        end
                    end else begin
                        chk($sformatf("hold_d%0d_p%0d", d, p), rdv, last_dat[d][p]);
                    end
                end
            end
        end
    end

    initial begin
        int na, nb;
        we = 0; waddr = 0; wmask = 0; wdata = 0; re = 0; raddr = 0; clr = 0; rst = 0;
        clr_left[0] = 0; clr_left[1] = 0;
        mdl_forget();
        #1;
        do_reset();

        // Full clear, then corner addresses read back as zero.
        run_clear(na, nb);
        chk("clear_len_a", 64'(na), 64'd64);
        chk("clear_len_b", 64'(nb), 64'd48);
        rd2(6'd0, 6'd63);
        idle();

        // Masked writes merge lanes.
        wr(6'd5, 4'b1111, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
        wr(6'd5, 4'b0101, {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD});
        rd2(6'd5, 6'd5);
        idle();

        // Same-cycle write/read collision on a zeroed word.
        drive(1'b1, 6'd7, 4'b0011, {16'd1, 16'd2, 16'd3, 16'd4}, 2'b11, 6'd7, 6'd7, 1'b0);
        rd2(6'd7, 6'd7);
        idle();

        // Clear with a same-cycle write (dropped) and read (pre-clear data); reads ignored while busy.
        wr(6'd2, 4'b1111, 64'h0102_0304_0506_0708);
        drive(1'b1, 6'd2, 4'b1111, 64'hFFFF_EEEE_DDDD_CCCC, 2'b11, 6'd2, 6'd5, 1'b1);
        na = 0;
        for (int i = 0; i < 200 && busy_a; i++) begin
            na++;
            drive(1'b1, 6'd2, 4'b1111, 64'h1234_5678_9ABC_DEF0, 2'b11,
                  6'($urandom_range(0, 63)), 6'd2, 1'b0);
        end
        chk("clear_len_blocked_a", 64'(na), 64'd64);
        rd2(6'd2, 6'd2);
        idle();

        // Out-of-range write and read on the 48-word instance.
        wr(6'd47, 4'b1111, 64'h4747_4747_4747_4747);
        wr(6'd50, 4'b1111, 64'h5050_5050_5050_5050);
        rd2(6'd50, 6'd47);
        idle();

        // Reset during the 20th clear cycle, then a full-length clear again.
        drive(1'b0, 6'd0, 4'd0, 64'd0, 2'b00, 6'd0, 6'd0, 1'b1);
        for (int i = 0; i < 19; i++) idle();
        do_reset();
        run_clear(na, nb);
        chk("clear_len_after_rst_a", 64'(na), 64'd64);
        chk("clear_len_after_rst_b", 64'(nb), 64'd48);

        // Randomised traffic, occasional clears.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)),
                  {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                  6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                  1'($urandom_range(0, 79) == 0));
        end
        for (int i = 0; i < 200 && (busy_a || busy_b); i++) idle();
        idle();
        idle();
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
